// File: rtl/uart_rx_8n1_if.sv
// Parallel receive bus of the UART receiver: received byte, status strobes and busy flag.
interface uart_rx_8n1_if;
    logic [7:0] bus_out;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       rx_busy;

    modport master (
        output bus_out,
        output rx_valid,
        output frame_err,
        output parity_err,
        output rx_busy
    );

    modport slave (
        input bus_out,
        input rx_valid,
        input frame_err,
        input parity_err,
        input rx_busy
    );
endinterface

// File: rtl/uart_rx_8n1.sv
// UART receiver, 1 start / 8 data (LSB first) / optional parity / 1 stop.
// Each bit is decided by a 2-of-3 majority around mid-bit; the receiver
// returns to IDLE in the middle of the stop bit so a back-to-back start
// edge is not missed.
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx_in,
    uart_rx_8n1_if.master   rx_bus
);

    localparam int   CW  = $clog2(CLKS_PER_BIT);
    localparam int   M   = CLKS_PER_BIT / 2;
    localparam logic ODD = (PARITY == 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [2:0]      idx_reg, idx_next;
    logic [7:0]      shift_reg, shift_next;
    logic [7:0]      data_reg, data_next;
    logic            s0_reg, s0_next;
    logic            s1_reg, s1_next;
    logic            mism_reg, mism_next;
    logic            stop_seen_reg, stop_seen_next;
    logic            stop_bit_reg, stop_bit_next;
    logic            valid_reg, valid_next;
    logic            ferr_reg, ferr_next;
    logic            perr_reg, perr_next;

    logic            sync1_reg, rx_s_reg, rx_prev_reg;
    logic            fall, wrap, at_s0, at_s1, at_dec, maj;

    assign fall   = rx_prev_reg & ~rx_s_reg;
    assign wrap   = (cnt_reg == CW'(CLKS_PER_BIT - 1));
    assign at_s0  = (cnt_reg == CW'(M - 1));
    assign at_s1  = (cnt_reg == CW'(M));
    assign at_dec = (cnt_reg == CW'(M + 1));
    assign maj    = (s0_reg & s1_reg) | (s0_reg & rx_s_reg) | (s1_reg & rx_s_reg);

    // Two-flop synchronizer plus edge register; all load the idle level on reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_reg   <= 1'b1;
            rx_s_reg    <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            sync1_reg   <= rx_in;
            rx_s_reg    <= sync1_reg;
            rx_prev_reg <= rx_s_reg;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            shift_reg     <= '0;
            data_reg      <= '0;
            s0_reg        <= 1'b0;
            s1_reg        <= 1'b0;
            mism_reg      <= 1'b0;
            stop_seen_reg <= 1'b0;
            stop_bit_reg  <= 1'b0;
            valid_reg     <= 1'b0;
            ferr_reg      <= 1'b0;
            perr_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            shift_reg     <= shift_next;
            data_reg      <= data_next;
            s0_reg        <= s0_next;
            s1_reg        <= s1_next;
            mism_reg      <= mism_next;
            stop_seen_reg <= stop_seen_next;
            stop_bit_reg  <= stop_bit_next;
            valid_reg     <= valid_next;
            ferr_reg      <= ferr_next;
            perr_reg      <= perr_next;
        end
    end

    // Next-state, bit timing, sampling and strobe generation.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        idx_next       = idx_reg;
        shift_next     = shift_reg;
        data_next      = data_reg;
        s0_next        = s0_reg;
        s1_next        = s1_reg;
        mism_next      = mism_reg;
        stop_seen_next = stop_seen_reg;
        stop_bit_next  = stop_bit_reg;
        valid_next     = 1'b0;
        ferr_next      = 1'b0;
        perr_next      = 1'b0;

        if (state_reg != IDLE) begin
            cnt_next = wrap ? '0 : cnt_reg + 1'b1;
            if (at_s0) s0_next = rx_s_reg;
            if (at_s1) s1_next = rx_s_reg;
        end

        unique case (state_reg)
            IDLE: begin
                if (fall) begin
                    cnt_next       = '0;
                    mism_next      = 1'b0;
                    stop_seen_next = 1'b0;
                    state_next     = START;
                end
            end
            START: begin
                if (at_dec && maj) begin
                    state_next = IDLE;
                end else if (wrap) begin
                    idx_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (at_dec) shift_next = {maj, shift_reg[7:1]};
                if (wrap) begin
                    if (idx_reg == 3'd7)
                        state_next = (PARITY != 0) ? PAR : STOP;
                    else
                        idx_next = idx_reg + 3'd1;
                end
            end
            PAR: begin
                if (at_dec) mism_next = (maj != ((^shift_reg) ^ ODD));
                if (wrap) state_next = STOP;
            end
            STOP: begin
                if (stop_seen_reg) begin
                    stop_seen_next = 1'b0;
                    if (stop_bit_reg) begin
                        if (mism_reg) begin
                            perr_next = 1'b1;
                        end else begin
                            data_next  = shift_reg;
                            valid_next = 1'b1;
                        end
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        perr_next  = mism_reg;
                        state_next = BRK;
                    end
                end else if (at_dec) begin
                    stop_seen_next = 1'b1;
                    stop_bit_next  = maj;
                end
            end
            BRK: begin
                if (rx_s_reg) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rx_bus.bus_out    = data_reg;
    assign rx_bus.rx_valid   = valid_reg;
    assign rx_bus.frame_err  = ferr_reg;
    assign rx_bus.parity_err = perr_reg;
    assign rx_bus.rx_busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1: one receiver without parity, one with even parity.
module tb_uart_rx_8n1;

    localparam int CPB = 64;
    localparam int M   = CPB / 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    uart_rx_8n1_if if0 ();
    uart_rx_8n1_if if1 ();

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB), .PARITY(0)) dut (
        .clk(clk), .rst(rst), .rx_in(rx0), .rx_bus(if0)
    );

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB), .PARITY(2)) dut_p (
        .clk(clk), .rst(rst), .rx_in(rx1), .rx_bus(if1)
    );

    // Pulse counters and received-byte log, sampled just after each edge.
    int         vcnt0 = 0, fcnt0 = 0, pcnt0 = 0;
    int         vcnt1 = 0, fcnt1 = 0, pcnt1 = 0;
    int         cyc = 0, busy_fall_cyc = 0, busy_rises = 0;
    logic       busy_prev = 1'b0;
    logic [7:0] q0[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (if0.rx_valid)   begin vcnt0++; q0.push_back(if0.bus_out); end
        if (if0.frame_err)  fcnt0++;
        if (if0.parity_err) pcnt0++;
        if (if1.rx_valid)   vcnt1++;
        if (if1.frame_err)  fcnt1++;
        if (if1.parity_err) pcnt1++;
        if (busy_prev && !if0.rx_busy) busy_fall_cyc = cyc;
        if (!busy_prev && if0.rx_busy) busy_rises++;
        busy_prev = if0.rx_busy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: got 0x%0h", tag, got);
        end
    endtask

    task automatic line(input int which, input logic v, input int n);
        if (which == 0) rx0 = v; else rx1 = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int which, input logic [7:0] b, input logic use_par,
                              input logic par_v, input logic stop_v, input int glitch);
        line(which, 1'b0, CPB);
        for (int k = 0; k < 8; k++) begin
            if (k == glitch) begin
                line(which, b[k], M);
                line(which, ~b[k], 1);
                line(which, b[k], CPB - M - 1);
            end else begin
                line(which, b[k], CPB);
            end
        end
        if (use_par) line(which, par_v, CPB);
        line(which, stop_v, CPB);
    endtask

    initial begin
        int         v, f, p, v1, p1, f1, start, dur, br;
        logic [7:0] b;
        logic [31:0] d0, d1;

        // Reset state
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("reset bus_out",    if0.bus_out,    0);
        check("reset rx_valid",   if0.rx_valid,   0);
        check("reset frame_err",  if0.frame_err,  0);
        check("reset parity_err", if0.parity_err, 0);
        check("reset rx_busy",    if0.rx_busy,    0);
        rst = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        // 0x55, single frame
        v = vcnt0; f = fcnt0; p = pcnt0; start = cyc;
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, -1);
        line(0, 1'b1, 2 * CPB);
        dur = busy_fall_cyc - start;
        check("0x55 valid count", vcnt0 - v, 1);
        check("0x55 bus_out",     if0.bus_out, 8'h55);
        check("0x55 no errors",   (fcnt0 - f) + (pcnt0 - p), 0);
        check("0x55 busy ~9.5 bits", (dur >= 9 * CPB) && (dur <= 10 * CPB), 1);

        // 0x00 then 0xFF back-to-back
        q0.delete(); v = vcnt0; f = fcnt0; p = pcnt0;
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1, -1);
        send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1, -1);
        line(0, 1'b1, 2 * CPB);
        d0 = (q0.size() > 0) ? 32'(q0[0]) : 32'hDEAD;
        d1 = (q0.size() > 1) ? 32'(q0[1]) : 32'hDEAD;
        check("b2b valid count", vcnt0 - v, 2);
        check("b2b first byte",  d0, 8'h00);
        check("b2b second byte", d1, 8'hFF);
        check("b2b no errors",   (fcnt0 - f) + (pcnt0 - p), 0);

        // False start: low for less than half a bit
        v = vcnt0; f = fcnt0; p = pcnt0; br = busy_rises;
        line(0, 1'b0, 20);
        line(0, 1'b1, 2 * CPB);
        check("false start busy seen", busy_rises - br, 1);
        check("false start no pulses", (vcnt0 - v) + (fcnt0 - f) + (pcnt0 - p), 0);
        check("false start busy low",  if0.rx_busy, 0);

        // 0xA3 with stop bit low, then break
        v = vcnt0; f = fcnt0; p = pcnt0;
        send_frame(0, 8'hA3, 1'b0, 1'b0, 1'b0, -1);
        line(0, 1'b0, 3 * CPB);
        check("break frame_err count", fcnt0 - f, 1);
        check("break no valid",        vcnt0 - v, 0);
        check("break bus_out held",    if0.bus_out, 8'hFF);
        check("break busy high",       if0.rx_busy, 1);
        line(0, 1'b1, 8);
        check("break busy released",   if0.rx_busy, 0);
        line(0, 1'b1, 2 * CPB);
        check("break single frame_err", fcnt0 - f, 1);

        // Even parity receiver: 0x07 has three ones, so the parity bit must be 1
        v1 = vcnt1; p1 = pcnt1; f1 = fcnt1;
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, -1);
        line(1, 1'b1, 2 * CPB);
        check("parity bad parity_err", pcnt1 - p1, 1);
        check("parity bad no valid",   vcnt1 - v1, 0);
        v1 = vcnt1; p1 = pcnt1;
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, -1);
        line(1, 1'b1, 2 * CPB);
        check("parity good valid",     vcnt1 - v1, 1);
        check("parity good bus_out",   if1.bus_out, 8'h07);
        check("parity good no errors", (pcnt1 - p1) + (fcnt1 - f1), 0);

        // Reset during data bit 4 of 0x3C
        v = vcnt0; f = fcnt0; p = pcnt0; b = 8'h3C;
        line(0, 1'b0, CPB);
        for (int k = 0; k < 4; k++) line(0, b[k], CPB);
        line(0, b[4], M);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("mid reset bus_out",  if0.bus_out, 0);
        check("mid reset rx_busy",  if0.rx_busy, 0);
        check("mid reset strobes",  {if0.rx_valid, if0.frame_err, if0.parity_err}, 0);
        line(0, 1'b1, 2 * CPB);
        check("mid reset no pulses", (vcnt0 - v) + (fcnt0 - f) + (pcnt0 - p), 0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, -1);
        line(0, 1'b1, 2 * CPB);
        check("after reset valid",   vcnt0 - v, 1);
        check("after reset bus_out", if0.bus_out, 8'h3C);

        // One-cycle spike in the middle of data bit 3
        v = vcnt0; f = fcnt0; p = pcnt0;
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1, 3);
        line(0, 1'b1, 2 * CPB);
        check("glitch valid",     vcnt0 - v, 1);
        check("glitch bus_out",   if0.bus_out, 8'h00);
        check("glitch no errors", (fcnt0 - f) + (pcnt0 - p), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
